axi4_lite_rr_arbiter: RTL

Round-robin arbiter that lets N_REQ simple requesters share one AXI4-Lite slave, such as the `axi4_lite_memory_slave` register memory. Each requester presents a single-beat read or write command. The arbiter grants one requester at a time, runs the full AXI4-Lite handshake sequence on its master port, and returns the read data and response status to the granted requester. It sits between the processing blocks and the AXI4-Lite bus.

---
 rtl/axi4_lite_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin arbiter: N_REQ single-beat requesters share one AXI4-Lite slave.
// One transaction in flight; payload latched at grant; all outputs registered.
module axi4_lite_rr_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*32-1:0]           req_wdata,
  input  logic [N_REQ*4-1:0]            req_wstrb,
  output logic [N_REQ-1:0]              ack,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [31:0]                   m_wdata,
  output logic [3:0]                    m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic                          m_bvalid,
  input  logic [1:0]                    m_bresp,
  output logic                          m_bready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic                          m_rvalid,
  input  logic [31:0]                   m_rdata,
  input  logic [1:0]                    m_rresp,
  output logic                          m_rready
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, ACK} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     last_grant, pick, idx;
  logic [N_REQ-1:0]  grant_oh;
  logic              aw_done, w_done, aw_fire, w_fire;

  assign aw_fire  = m_awvalid & m_awready;
  assign w_fire   = m_wvalid & m_wready;
  assign grant_oh = N_REQ'(1) << grant_id;

  // Descending scan so the smallest offset past last_grant wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int o = N_REQ; o >= 1; o--) begin
      idx = GW'((int'(last_grant) + o) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = req_we[pick] ? WR_AW_W : RD_AR;
      WR_AW_W: if ((aw_done | aw_fire) && (w_done | w_fire)) state_nxt = WR_B;
      WR_B:    if (m_bvalid) state_nxt = ACK;
      RD_AR:   if (m_arready) state_nxt = RD_R;
      RD_R:    if (m_rvalid) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ack        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      m_awaddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (|req) begin
          grant_id   <= pick;
          last_grant <= pick;
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
          if (req_we[pick]) begin
            m_awaddr  <= req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata   <= req_wdata[int'(pick)*32 +: 32];
            m_wstrb   <= req_wstrb[int'(pick)*4 +: 4];
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end else begin
            m_araddr  <= req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            m_arvalid <= 1'b1;
          end
        end
        WR_AW_W: begin
          if (aw_fire) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if (state_nxt == WR_B) m_bready <= 1'b1;
        end
        WR_B: if (m_bvalid) begin
          m_bready  <= 1'b0;
          rsp_err   <= (m_bresp != 2'b00);
          rsp_rdata <= '0;
          ack       <= grant_oh;
        end
        RD_AR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
        end
        RD_R: if (m_rvalid) begin
          m_rready  <= 1'b0;
          rsp_rdata <= m_rdata;
          rsp_err   <= (m_rresp != 2'b00);
          ack       <= grant_oh;
        end
        default: ;
      endcase
    end
  end

endmodule
